// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM microphone front end with a 3rd-order CIC decimator.
//   clk_in          : system clock; the only clock in the block
//   rst_in          : synchronous active-high reset
//   mic_data_in     : PDM bit from the microphone, sampled once per mic clock
//   mic_clk_out     : registered mic clock, period CLK_DIV, 50% duty
//   audio_out       : signed 16-bit PCM, holds between strobes
//   audio_valid_out : one-cycle strobe, once every CLK_DIV*DECIM cycles
//   clip_out        : with the strobe, set when the sample was saturated
module pdm_decimator #(
  parameter int CLK_DIV = 32,
  parameter int DECIM   = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               mic_data_in,
  output logic               mic_clk_out,
  output logic signed [15:0] audio_out,
  output logic               audio_valid_out,
  output logic               clip_out
);
  localparam int LOG2D = $clog2(DECIM);
  localparam int W     = 2 + 3 * LOG2D;
  localparam int SHIFT = 3 * LOG2D - 15;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic signed [W-1:0] S_MAX    = W'(32767);
  localparam logic signed [W-1:0] S_MIN    = W'(-32768);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [LOG2D-1:0] dec_cnt_q, dec_cnt_d;
  logic             mic_clk_q, mic_clk_d;
  logic [W-1:0]     i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [W-1:0]     c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  // vld_pipe_q[k] set: comb stage k+1 fires on this edge; [3] drives the output
  logic [3:0]       vld_pipe_q, vld_pipe_d;
  logic signed [15:0] audio_q, audio_d;
  logic             valid_q, valid_d;
  logic             clip_q, clip_d;

  logic             tick;
  logic             dec_evt;
  logic [W-1:0]     x_w;
  logic signed [W-1:0] s_w;

  always_comb begin
    tick    = (div_cnt_q == DIV_HALF);
    dec_evt = tick && (dec_cnt_q == '1);

    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    mic_clk_d = (div_cnt_q < DIV_HALF);
    dec_cnt_d = tick ? dec_cnt_q + LOG2D'(1) : dec_cnt_q;

    // +1 / -1 in W-bit two's complement; all sums wrap modulo 2^W
    x_w  = mic_data_in ? W'(1) : '1;
    i1_d = tick ? i1_q + x_w  : i1_q;
    i2_d = tick ? i2_q + i1_d : i2_q;
    i3_d = tick ? i3_q + i2_d : i3_q;

    vld_pipe_d = {vld_pipe_q[2:0], dec_evt};

    // i3_q already holds the post-decimation-tick value when stage 1 fires
    c1_d = vld_pipe_q[0] ? i3_q - d1_q : c1_q;
    d1_d = vld_pipe_q[0] ? i3_q        : d1_q;
    c2_d = vld_pipe_q[1] ? c1_q - d2_q : c2_q;
    d2_d = vld_pipe_q[1] ? c1_q        : d2_q;
    c3_d = vld_pipe_q[2] ? c2_q - d3_q : c3_q;
    d3_d = vld_pipe_q[2] ? c2_q        : d3_q;

    s_w     = $signed(c3_q) >>> SHIFT;
    audio_d = audio_q;
    valid_d = 1'b0;
    clip_d  = 1'b0;
    if (vld_pipe_q[3]) begin
      valid_d = 1'b1;
      if (s_w > S_MAX) begin
        audio_d = 16'sh7fff;
        clip_d  = 1'b1;
      end else if (s_w < S_MIN) begin
        audio_d = -16'sh8000;
        clip_d  = 1'b1;
      end else begin
        audio_d = s_w[15:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt_q  <= '0;
      dec_cnt_q  <= '0;
      mic_clk_q  <= 1'b0;
      i1_q       <= '0;
      i2_q       <= '0;
      i3_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      d3_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      c3_q       <= '0;
      vld_pipe_q <= '0;
      audio_q    <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      mic_clk_q  <= mic_clk_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      i3_q       <= i3_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      d3_q       <= d3_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      c3_q       <= c3_d;
      vld_pipe_q <= vld_pipe_d;
      audio_q    <= audio_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
    end
  end

  assign mic_clk_out     = mic_clk_q;
  assign audio_out       = audio_q;
  assign audio_valid_out = valid_q;
  assign clip_out        = clip_q;
endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: self-checking bench for pdm_decimator at default parameters.
// Expected strobes (cycle, value, clip) are queued when a pattern is started and
// popped by a monitor as the DUT strobes.
module tb_pdm_decimator;
  localparam int CLK_DIV = 32;
  localparam int DECIM   = 64;
  localparam int BLK     = CLK_DIV * DECIM;
  // cyc counts edges since release, so after edge k it reads k+1
  localparam int FIRST   = CLK_DIV * (DECIM - 1) + CLK_DIV / 2 + 4 + 1;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               mic_data_in;
  logic               mic_clk_out;
  logic signed [15:0] audio_out;
  logic               audio_valid_out;
  logic               clip_out;

  pdm_decimator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .mic_data_in     (mic_data_in),
    .mic_clk_out     (mic_clk_out),
    .audio_out       (audio_out),
    .audio_valid_out (audio_valid_out),
    .clip_out        (clip_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int                 pat;   // 0: all zeros, 1: all ones, 2: alternating 1,0
    int                 nblk;
    logic signed [15:0] aud;
    logic               clip;
  } vec_t;

  typedef struct {
    int                 cyc;
    bit                 chk;
    logic signed [15:0] aud;
    logic               clip;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pat = 1;
  int   mclk_bad = 0;
  int   clip_bad = 0;
  int   hold_bad = 0;
  logic signed [15:0] last_aud = '0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk_in) begin
    if (rst_in) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Bit n of the stream is presented while cyc/CLK_DIV == n, covering its tick.
  always_comb begin
    if (pat == 1)      mic_data_in = 1'b1;
    else if (pat == 0) mic_data_in = 1'b0;
    else               mic_data_in = ((cyc / CLK_DIV) % 2) == 0;
  end

  always @(negedge clk_in) begin
    if (rst_in) begin
      last_aud = '0;
    end else begin
      if (cyc >= 1 && mic_clk_out !== (((cyc - 1) % CLK_DIV) < CLK_DIV / 2))
        mclk_bad++;
      if (audio_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", cyc, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          if (e.chk) begin
            check("audio_out", longint'(audio_out), longint'(e.aud));
            check("clip_out", clip_out, e.clip);
          end
        end
        last_aud = audio_out;
      end else begin
        if (clip_out !== 1'b0) clip_bad++;
        if (audio_out !== last_aud) hold_bad++;
      end
    end
  end

  // Called at a negedge; leaves rst_in low at a negedge.
  task automatic do_reset(input int n);
    rst_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (i == 0) begin
        check("rst_mic_clk", mic_clk_out, 0);
        check("rst_audio", longint'(audio_out), 0);
        check("rst_valid", audio_valid_out, 0);
        check("rst_clip", clip_out, 0);
      end
    end
    rst_in = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic end_checks(input string nm);
    check({nm, "_missing_strobes"}, sb.size(), 0);
    check({nm, "_mic_clk_shape"}, mclk_bad, 0);
    check({nm, "_clip_idle"}, clip_bad, 0);
    check({nm, "_audio_hold"}, hold_bad, 0);
    sb.delete();
  endtask

  vec_t vecs[3];

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{pat: 1, nblk: 12, aud: 16'sh7fff,  clip: 1'b1};
    vecs[1] = '{pat: 0, nblk: 5,  aud: -16'sh8000, clip: 1'b0};
    vecs[2] = '{pat: 2, nblk: 5,  aud: 16'sh0000,  clip: 1'b0};
    rst_in = 1'b1;
    @(negedge clk_in);

    // 12 blocks of ones: integrators wrap many times, output must stay pinned
    for (int v = 0; v < 3; v++) begin
      pat = vecs[v].pat;
      do_reset(3);
      for (int m = 0; m < vecs[v].nblk; m++)
        sb.push_back('{cyc: FIRST + m * BLK, chk: (m >= 3),
                       aud: vecs[v].aud, clip: vecs[v].clip});
      run_until(FIRST + (vecs[v].nblk - 1) * BLK + 3);
      end_checks($sformatf("pat%0d", vecs[v].pat));
    end

    // Reset pulse mid-block (dec_cnt = 40): restart timing from release
    pat = 1;
    do_reset(2);
    run_until(40 * CLK_DIV + 20);
    do_reset(1);
    sb.push_back('{cyc: FIRST, chk: 1'b0, aud: '0, clip: 1'b0});
    run_until(FIRST + 3);
    end_checks("rst_midblock");

    // Reset pulse inside the comb pipeline: the pending sample must vanish
    do_reset(2);
    run_until(FIRST - 3);
    do_reset(1);
    sb.push_back('{cyc: FIRST, chk: 1'b0, aud: '0, clip: 1'b0});
    run_until(FIRST + 3);
    end_checks("rst_midcomb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
